// File: rtl/xbar_pkg.sv
// Shared types for the crossbar response router: chip indices and the
// per-request tracking entry kept in the in-order FIFO.
package xbar_pkg;

  localparam int CHIP_W = 2;
  localparam int SEL_W  = 6;

  typedef logic [CHIP_W-1:0] chip_idx_t;

  localparam chip_idx_t CHIP_ROM    = 2'd0;
  localparam chip_idx_t CHIP_FLASH  = 2'd1;
  localparam chip_idx_t CHIP_PERIPH = 2'd2;
  localparam chip_idx_t CHIP_RAM    = 2'd3;

  // err set means the request never left the router and is answered locally
  typedef struct packed {
    logic      err;
    chip_idx_t chip;
  } resp_entry_t;

endpackage

// File: rtl/xbar_order_fifo.sv
// Synchronous FIFO of tracking entries; occupancy counter drives full/empty,
// pointers wrap modulo DEPTH. The head entry is read straight from storage.
module xbar_order_fifo
  import xbar_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  resp_entry_t              wdata,
  input  logic                     pop,
  output resp_entry_t              head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  resp_entry_t         mem [DEPTH];
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic                do_push;
  logic                do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Pointer and occupancy update; push+pop together leaves count unchanged
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  // Entry storage, cleared on reset so the head never shows stale data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

endmodule

// File: rtl/xbar_resp_router.sv
// Request-forward / response-return router. Requests are steered to the
// decoder-selected chip and logged in order; responses return to the master
// strictly in request order, unmapped requests get a local denied response.
//
// Handshakes: every channel is valid/ready; a transfer happens on a rising
// edge where both are high. valid never depends on ready of the same channel
// except where it is passed through from the other side (m_d_valid from
// s_d_valid of the head chip); stray slave responses are held, never dropped.
module xbar_resp_router
  import xbar_pkg::*;
#(
  parameter int NCHIP = 4,
  parameter int DEPTH = 4,
  parameter int DW    = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   m_a_valid,
  output logic                   m_a_ready,
  input  logic                   m_a_hit,
  input  logic [SEL_W-1:0]       m_a_sel,
  output logic [NCHIP-1:0]       s_a_valid,
  input  logic [NCHIP-1:0]       s_a_ready,
  input  logic [NCHIP-1:0]       s_d_valid,
  input  logic [NCHIP*DW-1:0]    s_d_data,
  output logic [NCHIP-1:0]       s_d_ready,
  output logic                   m_d_valid,
  output logic [DW-1:0]          m_d_data,
  output logic                   m_d_denied,
  input  logic                   m_d_ready,
  output logic [$clog2(DEPTH):0] outstanding,
  output logic [15:0]            err_cnt
);

  resp_entry_t a_entry;
  resp_entry_t head;
  logic        fifo_full;
  logic        fifo_empty;
  logic        push;
  logic        pop;
  chip_idx_t   a_chip;
  chip_idx_t   d_chip;

  assign a_chip        = m_a_sel[CHIP_W-1:0];
  assign a_entry.err   = !m_a_hit || (32'(m_a_sel) >= 32'(NCHIP));
  assign a_entry.chip  = a_chip;
  assign d_chip        = head.chip;
  assign push          = m_a_valid && m_a_ready;
  assign pop           = m_d_valid && m_d_ready;

  // A path: steer the request, or absorb it locally when unmapped
  always_comb begin
    s_a_valid = '0;
    m_a_ready = 1'b0;
    if (!fifo_full) begin
      if (a_entry.err) begin
        m_a_ready = 1'b1;
      end else begin
        s_a_valid[a_chip] = m_a_valid;
        m_a_ready         = s_a_ready[a_chip];
      end
    end
  end

  // D path: only the chip recorded at the FIFO head may answer
  always_comb begin
    m_d_valid  = 1'b0;
    m_d_data   = '0;
    m_d_denied = 1'b0;
    s_d_ready  = '0;
    if (!fifo_empty) begin
      if (head.err) begin
        m_d_valid  = 1'b1;
        m_d_denied = 1'b1;
      end else begin
        m_d_valid         = s_d_valid[d_chip];
        m_d_data          = s_d_data[int'(d_chip)*DW +: DW];
        s_d_ready[d_chip] = m_d_ready;
      end
    end
  end

  // Count denied responses delivered to the master, saturating
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (pop && head.err && (err_cnt != 16'hFFFF)) begin
      err_cnt <= err_cnt + 16'd1;
    end
  end

  xbar_order_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (a_entry),
    .pop   (pop),
    .head  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (outstanding)
  );

endmodule

// File: tb/tb_xbar_resp_router.sv
// Bench for xbar_resp_router: directed scenarios followed by random traffic,
// all checked against an in-order request queue model.
module tb_xbar_resp_router;

  localparam int NCHIP = 4;
  localparam int DEPTH = 4;
  localparam int DW    = 64;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                m_a_valid, m_a_ready, m_a_hit;
  logic [5:0]          m_a_sel;
  logic [NCHIP-1:0]    s_a_valid, s_a_ready, s_d_valid, s_d_ready;
  logic [NCHIP*DW-1:0] s_d_data;
  logic                m_d_valid, m_d_denied, m_d_ready;
  logic [DW-1:0]       m_d_data;
  logic [2:0]          outstanding;
  logic [15:0]         err_cnt;

  xbar_resp_router #(.NCHIP(NCHIP), .DEPTH(DEPTH), .DW(DW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .m_a_valid   (m_a_valid),
    .m_a_ready   (m_a_ready),
    .m_a_hit     (m_a_hit),
    .m_a_sel     (m_a_sel),
    .s_a_valid   (s_a_valid),
    .s_a_ready   (s_a_ready),
    .s_d_valid   (s_d_valid),
    .s_d_data    (s_d_data),
    .s_d_ready   (s_d_ready),
    .m_d_valid   (m_d_valid),
    .m_d_data    (m_d_data),
    .m_d_denied  (m_d_denied),
    .m_d_ready   (m_d_ready),
    .outstanding (outstanding),
    .err_cnt     (err_cnt)
  );

  // scoreboard: outstanding requests in order, {err, sel}
  logic [6:0]  exp_q[$];
  logic [63:0] chip_q[NCHIP][$];
  int          exp_err_cnt = 0;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    m_a_valid = 1'b0; m_a_hit = 1'b0; m_a_sel = '0;
    s_a_ready = '0;   s_d_valid = '0; s_d_data = '0;
    m_d_ready = 1'b0;
  endtask

  task automatic model_clear();
    exp_q.delete();
    for (int c = 0; c < NCHIP; c++) chip_q[c].delete();
    exp_err_cnt = 0;
  endtask

  // one cycle: check all outputs against the model, clock, update the model
  task automatic step();
    logic        a_err, e_ar, e_mdv, e_den, push, pop;
    logic [3:0]  e_sav, e_sdr;
    logic [63:0] e_mdd;
    logic [6:0]  hd;
    int          c;
    a_err = !m_a_hit || (m_a_sel >= 6'd4);
    e_sav = '0; e_ar = 1'b0;
    if (exp_q.size() < DEPTH) begin
      if (a_err) e_ar = 1'b1;
      else begin
        e_sav[m_a_sel[1:0]] = m_a_valid;
        e_ar = s_a_ready[m_a_sel[1:0]];
      end
    end
    e_mdv = 1'b0; e_den = 1'b0; e_mdd = '0; e_sdr = '0; hd = '0;
    if (exp_q.size() > 0) begin
      hd = exp_q[0];
      if (hd[6]) begin
        e_mdv = 1'b1; e_den = 1'b1;
      end else begin
        c = int'(hd[5:0]);
        e_mdv = s_d_valid[c];
        e_mdd = s_d_data[c*DW +: DW];
        e_sdr[c] = m_d_ready;
      end
    end
    #1;
    chk("m_a_ready",   64'(m_a_ready),   64'(e_ar));
    chk("s_a_valid",   64'(s_a_valid),   64'(e_sav));
    chk("m_d_valid",   64'(m_d_valid),   64'(e_mdv));
    chk("m_d_denied",  64'(m_d_denied),  64'(e_den));
    chk("m_d_data",    m_d_data,         e_mdd);
    chk("s_d_ready",   64'(s_d_ready),   64'(e_sdr));
    chk("outstanding", 64'(outstanding), 64'(exp_q.size()));
    chk("err_cnt",     64'(err_cnt),     64'(exp_err_cnt));
    push = m_a_valid && e_ar;
    pop  = e_mdv && m_d_ready;
    @(posedge clk);
    if (pop) begin
      if (hd[6]) begin
        if (exp_err_cnt < 16'hFFFF) exp_err_cnt++;
      end else begin
        void'(chip_q[int'(hd[5:0])].pop_front());
      end
      void'(exp_q.pop_front());
    end
    if (push) begin
      exp_q.push_back({a_err, m_a_sel});
      if (!a_err) chip_q[m_a_sel[1:0]].push_back({$urandom, $urandom});
    end
    #1;
  endtask

  initial begin
    idle();
    // 1. reset then idle
    repeat (2) @(posedge clk);
    #1;
    chk("rst_outstanding", 64'(outstanding), 64'd0);
    chk("rst_m_d_valid",   64'(m_d_valid),   64'd0);
    rst_n = 1'b1;
    step(); step();

    // 2. request to RAM, response four cycles later
    m_a_valid = 1'b1; m_a_hit = 1'b1; m_a_sel = 6'd3; s_a_ready = 4'b1000;
    step();
    idle();
    step(); step(); step();
    s_d_valid = 4'b1000; s_d_data[3*DW +: DW] = 64'hDEAD; m_d_ready = 1'b1;
    step();
    chk("t2_outstanding_after", 64'(outstanding), 64'd0);
    idle();

    // 3. chip1 then chip2; chip2 answers first and must wait
    m_a_valid = 1'b1; m_a_hit = 1'b1; m_a_sel = 6'd1; s_a_ready = 4'b0110;
    step();
    m_a_sel = 6'd2;
    step();
    idle();
    m_d_ready = 1'b1; s_d_valid = 4'b0100; s_d_data[2*DW +: DW] = 64'h2222;
    step(); step();
    chk("t3_held", 64'(outstanding), 64'd2);
    s_d_valid = 4'b0110; s_d_data[1*DW +: DW] = 64'h1111;
    step();
    s_d_valid = 4'b0100;
    step();
    idle();
    step();

    // 4. unmapped request answered locally
    m_a_valid = 1'b1; m_a_hit = 1'b0; m_a_sel = 6'd2;
    step();
    idle();
    m_d_ready = 1'b1;
    step();
    chk("t4_err_cnt", 64'(err_cnt), 64'd1);
    idle();

    // 5. fill the FIFO, then a pop in the same cycle does not let a push in
    m_a_valid = 1'b1; m_a_hit = 1'b1; s_a_ready = 4'b1111;
    for (int i = 0; i < DEPTH; i++) begin
      m_a_sel = 6'(i);
      step();
    end
    chk("t5_full", 64'(outstanding), 64'd4);
    m_a_sel = 6'd1;
    step();
    s_d_valid = 4'b0001; m_d_ready = 1'b1;
    step();
    s_d_valid = 4'b0000; m_d_ready = 1'b0;
    step();
    chk("t5_refill", 64'(outstanding), 64'd4);
    idle();

    // 6. asynchronous reset with outstanding requests
    rst_n = 1'b0;
    #1;
    chk("t6_outstanding", 64'(outstanding), 64'd0);
    chk("t6_m_d_valid",   64'(m_d_valid),   64'd0);
    model_clear();
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_a_valid = 1'b1; m_a_hit = 1'b1; m_a_sel = 6'd0; s_a_ready = 4'b0001;
    step();
    idle();
    s_d_valid = 4'b0001; s_d_data[0 +: DW] = 64'hC0FFEE; m_d_ready = 1'b1;
    step();
    idle();
    step();

    // random traffic, slaves answer only what they owe
    for (int n = 0; n < 600; n++) begin
      m_a_valid = 1'($urandom_range(0, 1));
      m_a_hit   = ($urandom_range(0, 7) != 0);
      m_a_sel   = 6'($urandom_range(0, 5));
      s_a_ready = 4'($urandom_range(0, 15));
      m_d_ready = ($urandom_range(0, 3) != 0);
      for (int c = 0; c < NCHIP; c++) begin
        if (chip_q[c].size() > 0 && $urandom_range(0, 2) != 0) begin
          s_d_valid[c] = 1'b1;
          s_d_data[c*DW +: DW] = chip_q[c][0];
        end else begin
          s_d_valid[c] = 1'b0;
          s_d_data[c*DW +: DW] = {$urandom, $urandom};
        end
      end
      step();
    end
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
